// File: rtl/jtdd_adpcm_arb.sv
// jtdd_adpcm_arb: lets the two ADPCM decoder channels share one sample-ROM port.
// Each channel keeps one cached byte with its address tag. A channel whose
// cache misses gets a ROM fetch. When both channels miss, the grant goes to
// the channel that was not served last, so the two channels alternate.
module jtdd_adpcm_arb #(
    parameter int AW     = 16,
    parameter int DW     = 8,
    parameter int SETTLE = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ch0_cs,
    input  logic [AW-1:0] ch0_addr,
    output logic [DW-1:0] ch0_data,
    output logic          ch0_ok,
    input  logic          ch1_cs,
    input  logic [AW-1:0] ch1_addr,
    output logic [DW-1:0] ch1_data,
    output logic          ch1_ok,
    output logic [AW:0]   rom_addr,
    output logic          rom_cs,
    input  logic [DW-1:0] rom_data,
    input  logic          rom_ok
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t        r_state;
    logic [1:0]    r_valid;
    logic [AW-1:0] r_tag0;
    logic [AW-1:0] r_tag1;
    logic [AW-1:0] r_req_addr;
    logic          r_last;
    logic          r_gnt;
    logic [2:0]    r_settle;

    logic          w_hit0;
    logic          w_hit1;
    logic          w_pend0;
    logic          w_pend1;
    logic          w_gnt;
    logic [AW-1:0] w_sel_addr;

    // Cache hit, miss and grant decode. ok is combinational, so it drops in the same cycle the address moves.
    always_comb begin
        w_hit0     = r_valid[0] && (r_tag0 == ch0_addr);
        w_hit1     = r_valid[1] && (r_tag1 == ch1_addr);
        w_pend0    = ch0_cs && !w_hit0;
        w_pend1    = ch1_cs && !w_hit1;
        ch0_ok     = ch0_cs && w_hit0;
        ch1_ok     = ch1_cs && w_hit1;
        w_gnt      = (w_pend0 && w_pend1) ? !r_last : w_pend1;
        w_sel_addr = w_gnt ? ch1_addr : ch0_addr;
    end

    // Fetch FSM: grant in IDLE, wait out the settle time, then capture on rom_ok and return to IDLE for one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            rom_cs     <= 1'b0;
            rom_addr   <= '0;
            ch0_data   <= '0;
            ch1_data   <= '0;
            r_valid    <= 2'b00;
            r_tag0     <= '0;
            r_tag1     <= '0;
            r_req_addr <= '0;
            r_last     <= 1'b1;
            r_gnt      <= 1'b0;
            r_settle   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pend0 || w_pend1) begin
                        rom_addr   <= {w_gnt, w_sel_addr};
                        r_req_addr <= w_sel_addr;
                        r_gnt      <= w_gnt;
                        rom_cs     <= 1'b1;
                        r_settle   <= 3'(SETTLE);
                        r_state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (r_settle != 3'd0) begin
                        r_settle <= r_settle - 3'd1;
                    end else if (rom_ok) begin
                        if (r_gnt) begin
                            ch1_data   <= rom_data;
                            r_tag1     <= r_req_addr;
                            r_valid[1] <= 1'b1;
                        end else begin
                            ch0_data   <= rom_data;
                            r_tag0     <= r_req_addr;
                            r_valid[0] <= 1'b1;
                        end
                        r_last  <= r_gnt;
                        rom_cs  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jtdd_adpcm_arb.sv
// tb_jtdd_adpcm_arb: directed scenarios plus random traffic for the ROM arbiter,
// compared every cycle against a transaction-level model of the two caches.
module tb_jtdd_adpcm_arb;

    localparam int AW     = 16;
    localparam int DW     = 8;
    localparam int SETTLE = 1;

    logic          clk;
    logic          rst_n;
    logic          ch0_cs;
    logic [AW-1:0] ch0_addr;
    logic [DW-1:0] ch0_data;
    logic          ch0_ok;
    logic          ch1_cs;
    logic [AW-1:0] ch1_addr;
    logic [DW-1:0] ch1_data;
    logic          ch1_ok;
    logic [AW:0]   rom_addr;
    logic          rom_cs;
    logic [DW-1:0] rom_data;
    logic          rom_ok;

    int totalChecks = 0;
    int badChecks   = 0;

    jtdd_adpcm_arb #(.AW(AW), .DW(DW), .SETTLE(SETTLE)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ch0_cs   (ch0_cs),
        .ch0_addr (ch0_addr),
        .ch0_data (ch0_data),
        .ch0_ok   (ch0_ok),
        .ch1_cs   (ch1_cs),
        .ch1_addr (ch1_addr),
        .ch1_data (ch1_data),
        .ch1_ok   (ch1_ok),
        .rom_addr (rom_addr),
        .rom_cs   (rom_cs),
        .rom_data (rom_data),
        .rom_ok   (rom_ok)
    );

    // Free-running clock, period 10
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        totalChecks++;
        if (actual !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic cs0, input logic [AW-1:0] a0, input logic cs1,
                                 input logic [AW-1:0] a1, input logic ok, input logic [DW-1:0] d);
        ch0_cs   = cs0;
        ch0_addr = a0;
        ch1_cs   = cs1;
        ch1_addr = a1;
        rom_ok   = ok;
        rom_data = d;
    endtask

    task automatic holdCycles(input int n);
        repeat (n) begin
            @(negedge clk);
            #3;
        end
    endtask

    // Reference model: one cached byte per channel, and at most one fetch in flight.
    // A fetch is granted on the first edge a miss is seen while nothing is in flight;
    // the first SETTLE edges afterwards ignore rom_ok, any later edge with rom_ok completes it.
    logic          mBusy;
    int            mEdges;
    logic          mGnt;
    logic [AW-1:0] mReq;
    logic [AW:0]   mRomAddr;
    logic          mLast;
    logic          mValid [2];
    logic [AW-1:0] mTag   [2];
    logic [DW-1:0] mData  [2];

    // Model advances on the same edges as the design, from the same inputs
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mBusy    = 1'b0;
            mEdges   = 0;
            mGnt     = 1'b0;
            mReq     = '0;
            mRomAddr = '0;
            mLast    = 1'b1;
            for (int i = 0; i < 2; i++) begin
                mValid[i] = 1'b0;
                mTag[i]   = '0;
                mData[i]  = '0;
            end
        end else if (!mBusy) begin
            logic p0, p1;
            p0 = ch0_cs && !(mValid[0] && mTag[0] == ch0_addr);
            p1 = ch1_cs && !(mValid[1] && mTag[1] == ch1_addr);
            if (p0 || p1) begin
                mGnt     = (p0 && p1) ? !mLast : p1;
                mReq     = mGnt ? ch1_addr : ch0_addr;
                mRomAddr = {mGnt, mReq};
                mBusy    = 1'b1;
                mEdges   = 0;
            end
        end else begin
            mEdges++;
            if (mEdges > SETTLE && rom_ok) begin
                mData[mGnt]  = rom_data;
                mTag[mGnt]   = mReq;
                mValid[mGnt] = 1'b1;
                mLast        = mGnt;
                mBusy        = 1'b0;
            end
        end
    end

    // Every cycle, compare all outputs with the model, away from the clock edge
    always @(negedge clk) begin
        #2;
        checkOutput("model rom_cs",   32'(rom_cs),   32'(mBusy));
        checkOutput("model rom_addr", 32'(rom_addr), 32'(mRomAddr));
        checkOutput("model ch0_ok",   32'(ch0_ok),   32'(ch0_cs && mValid[0] && mTag[0] == ch0_addr));
        checkOutput("model ch1_ok",   32'(ch1_ok),   32'(ch1_cs && mValid[1] && mTag[1] == ch1_addr));
        checkOutput("model ch0_data", 32'(ch0_data), 32'(mData[0]));
        checkOutput("model ch1_data", 32'(ch1_data), 32'(mData[1]));
    end

    // Directed scenarios followed by random traffic
    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 8'h00);
        holdCycles(2);
        checkOutput("reset rom_cs",   32'(rom_cs),   32'h0);
        checkOutput("reset rom_addr", 32'(rom_addr), 32'h0);
        rst_n = 1'b1;
        holdCycles(1);

        // Single fetch on channel 0
        $display("[TB] single fetch");
        applyStimulus(1'b1, 16'h1234, 1'b0, 16'h0, 1'b1, 8'hA5);
        holdCycles(1);
        checkOutput("single rom_addr", 32'(rom_addr), 32'h01234);
        checkOutput("single rom_cs",   32'(rom_cs),   32'h1);
        holdCycles(1);
        checkOutput("single ok early", 32'(ch0_ok),   32'h0);
        holdCycles(1);
        checkOutput("single ch0_ok",   32'(ch0_ok),   32'h1);
        checkOutput("single ch0_data", 32'(ch0_data), 32'hA5);
        checkOutput("single cs drop",  32'(rom_cs),   32'h0);

        // Reset in the middle of a slow fetch, then contention after release
        $display("[TB] reset mid-wait and contention");
        applyStimulus(1'b1, 16'h0055, 1'b0, 16'h0, 1'b0, 8'h00);
        holdCycles(2);
        checkOutput("pre-reset rom_cs", 32'(rom_cs), 32'h1);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("async rom_cs",   32'(rom_cs),   32'h0);
        checkOutput("async ch0_ok",   32'(ch0_ok),   32'h0);
        checkOutput("async ch0_data", 32'(ch0_data), 32'h0);
        checkOutput("async ch1_data", 32'(ch1_data), 32'h0);
        holdCycles(1);
        rst_n = 1'b1;
        applyStimulus(1'b1, 16'h0010, 1'b1, 16'h0020, 1'b1, 8'h5A);
        holdCycles(1);
        checkOutput("contend first", 32'(rom_addr), 32'h00010);
        holdCycles(2);
        checkOutput("contend ch0_ok", 32'(ch0_ok), 32'h1);
        holdCycles(1);
        checkOutput("contend second", 32'(rom_addr), 32'h10020);
        holdCycles(2);
        checkOutput("contend ch1_ok", 32'(ch1_ok), 32'h1);
        checkOutput("contend ch0 still", 32'(ch0_ok), 32'h1);

        // Stale rom_ok during the settle cycle must be ignored
        $display("[TB] stale rom_ok");
        applyStimulus(1'b1, 16'h0010, 1'b1, 16'h0030, 1'b1, 8'hFF);
        holdCycles(2);
        rom_data = 8'h3C;
        holdCycles(1);
        checkOutput("stale ch1_data", 32'(ch1_data), 32'h3C);
        checkOutput("stale ch1_ok",   32'(ch1_ok),   32'h1);

        // Slow ROM: address holds until rom_ok, then one idle cycle before ch1
        $display("[TB] slow rom");
        applyStimulus(1'b1, 16'h0040, 1'b1, 16'h0050, 1'b0, 8'h77);
        holdCycles(1);
        checkOutput("slow grant", 32'(rom_addr), 32'h00040);
        for (int k = 0; k < 4; k++) begin
            holdCycles(1);
            checkOutput("slow addr hold", 32'(rom_addr), 32'h00040);
            checkOutput("slow cs hold",   32'(rom_cs),   32'h1);
        end
        rom_ok = 1'b1;
        holdCycles(1);
        checkOutput("slow capture", 32'(ch0_data), 32'h77);
        checkOutput("slow idle gap", 32'(rom_cs), 32'h0);
        holdCycles(1);
        checkOutput("slow ch1 grant", 32'(rom_addr), 32'h10050);
        holdCycles(2);

        // Address change on the granted channel during WAIT
        $display("[TB] address change mid-fetch");
        applyStimulus(1'b1, 16'h0040, 1'b1, 16'h0100, 1'b0, 8'h21);
        holdCycles(1);
        checkOutput("move grant", 32'(rom_addr), 32'h10100);
        holdCycles(1);
        ch1_addr = 16'h0101;
        rom_ok   = 1'b1;
        holdCycles(1);
        checkOutput("move ok low", 32'(ch1_ok), 32'h0);
        holdCycles(1);
        checkOutput("move refetch", 32'(rom_addr), 32'h10101);
        holdCycles(2);
        checkOutput("move ok high", 32'(ch1_ok), 32'h1);

        // Cache persists across a cs drop
        ch0_cs = 1'b0;
        #1;
        checkOutput("persist off", 32'(ch0_ok), 32'h0);
        ch0_cs = 1'b1;
        #1;
        checkOutput("persist on", 32'(ch0_ok), 32'h1);
        holdCycles(1);

        // Random traffic over a small address set so hits, misses and contention all occur
        $display("[TB] random traffic");
        for (int c = 0; c < 1500; c++) begin
            applyStimulus($urandom_range(0, 9) < 7, 16'($urandom_range(0, 3) * 16'h0111),
                          $urandom_range(0, 9) < 7, 16'($urandom_range(0, 3) * 16'h0222),
                          $urandom_range(0, 9) < 4, 8'($urandom));
            holdCycles(1);
        end

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
